reg_file_mp: RTL and testbench

- Parametrised multi-read-port register file for the ARM core pipeline. Successor of the fixed 15×32, 2-read-port register file.
- Adds the following, all in one clock domain:
  - configurable width, depth and read-port count;
  - an integrated pending-write scoreboard, so the ID stage can detect RAW hazards;
  - optional write-to-read bypass.
- Sits between ID (read/issue) and WB (write-back).

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/reg_file_scoreboard.sv | 44 ++++
 rtl/reg_file_mp.sv | 85 ++++++++
 tb/tb_reg_file_mp.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the multi-port register file.
// The optional bypass feature is selected with REG_FILE_BYPASS_EN.
package reg_file_pkg;

  localparam int RF_WIDTH  = 32;
  localparam int RF_DEPTH  = 15;
  localparam int RF_ADDR_W = 4;
  localparam int RF_NUM_RD = 2;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_WIDTH-1:0]  rf_data_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on write-back.
// A same-cycle issue and write-back to one register leaves it pending (newer producer wins).
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              write_back_en,
  input  logic [ADDR_W-1:0] wb_dest,
  output logic [DEPTH-1:0]  pending
);

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;
  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;

  // Out-of-range destinations never match any decoded index, so they are ignored.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int r = 0; r < DEPTH; r++) begin
      set_vec[r] = issue_en && (issue_dest == ADDR_W'(r));
      clr_vec[r] = write_back_en && (wb_dest == ADDR_W'(r));
    end
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with integrated RAW scoreboard.
// Define REG_FILE_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = RF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_back_en,
  input  logic [ADDR_W-1:0]        WB_dest,
  input  logic [WIDTH-1:0]         WB_result,
  input  logic [NUM_RD*ADDR_W-1:0] src,
  input  logic [NUM_RD-1:0]        src_valid,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_dest,
  output logic [NUM_RD*WIDTH-1:0]  reg_out,
  output logic [NUM_RD-1:0]        hazard,
  output logic [DEPTH-1:0]         pending
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  reg_file_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .issue_en      (issue_en),
    .issue_dest    (issue_dest),
    .write_back_en (write_back_en),
    .wb_dest       (WB_dest),
    .pending       (pending)
  );

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (write_back_en && (WB_dest == ADDR_W'(i))) begin
        regs_d[i] = WB_result;
      end
    end
  end

  // Reset loads each register with its own index, which the pipeline relies on.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= WIDTH'(i);
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    reg_out = '0;
    hazard  = '0;
    rd_addr = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr = src[k*ADDR_W +: ADDR_W];
      if ({1'b0, rd_addr} < DEPTH_LIM) begin
        reg_out[k*WIDTH +: WIDTH] = regs_q[rd_addr];
        hazard[k]                 = src_valid[k] && pending[rd_addr];
`ifdef REG_FILE_BYPASS_EN
        // The producer completes this cycle, so its result replaces the stale value.
        if (write_back_en && (WB_dest == rd_addr)) begin
          reg_out[k*WIDTH +: WIDTH] = WB_result;
          hazard[k]                 = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: reset table, directed corner sequences, random run vs model.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int W      = RF_WIDTH;
  localparam int DEPTH  = RF_DEPTH;
  localparam int AW     = RF_ADDR_W;
  localparam int NUM_RD = RF_NUM_RD;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 write_back_en;
  logic [AW-1:0]        WB_dest;
  logic [W-1:0]         WB_result;
  logic [NUM_RD*AW-1:0] src;
  logic [NUM_RD-1:0]    src_valid;
  logic                 issue_en;
  logic [AW-1:0]        issue_dest;
  logic [NUM_RD*W-1:0]  reg_out;
  logic [NUM_RD-1:0]    hazard;
  logic [DEPTH-1:0]     pending;

  int n_checks = 0;
  int n_fail   = 0;

  rf_data_t m_regs [DEPTH];
  bit       m_pend [DEPTH];

  reg_file_mp dut (
    .clk           (clk),
    .rst           (rst),
    .write_back_en (write_back_en),
    .WB_dest       (WB_dest),
    .WB_result     (WB_result),
    .src           (src),
    .src_valid     (src_valid),
    .issue_en      (issue_en),
    .issue_dest    (issue_dest),
    .reg_out       (reg_out),
    .hazard        (hazard),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] s0;
    logic [AW-1:0] s1;
    logic [1:0]    v;
    logic [W-1:0]  e0;
    logic [W-1:0]  e1;
  } vec_t;

  // Architectural effect of one clock edge, using the current bench-driven inputs.
  function automatic void model_clock();
    int d;
    int id;
    d  = 32'(WB_dest);
    id = 32'(issue_dest);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_regs[i] = W'(i);
        m_pend[i] = 1'b0;
      end
    end else begin
      if (write_back_en && d < DEPTH) begin
        m_regs[d] = WB_result;
        m_pend[d] = 1'b0;
      end
      if (issue_en && id < DEPTH) m_pend[id] = 1'b1;
    end
  endfunction

  function automatic void model_outputs(output logic [NUM_RD*W-1:0] eo,
                                        output logic [NUM_RD-1:0] eh,
                                        output logic [DEPTH-1:0] ep);
    int a;
    eo = '0;
    eh = '0;
    ep = '0;
    for (int r = 0; r < DEPTH; r++) ep[r] = m_pend[r];
    for (int k = 0; k < NUM_RD; k++) begin
      a = 32'(src[k*AW +: AW]);
      if (a < DEPTH) begin
        eo[k*W +: W] = m_regs[a];
        eh[k]        = src_valid[k] && m_pend[a];
        if (BYPASS && write_back_en && 32'(WB_dest) == a) begin
          eo[k*W +: W] = WB_result;
          eh[k]        = 1'b0;
        end
      end
    end
  endfunction

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name);
    logic [NUM_RD*W-1:0] eo;
    logic [NUM_RD-1:0]   eh;
    logic [DEPTH-1:0]    ep;
    model_outputs(eo, eh, ep);
    checkValue({name, ".reg_out"}, reg_out, eo);
    checkValue({name, ".hazard"}, 64'(hazard), 64'(eh));
    checkValue({name, ".pending"}, 64'(pending), 64'(ep));
  endtask

  task automatic applyStimulus(input logic wbe, input logic [AW-1:0] dest, input logic [W-1:0] res,
                               input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                               input logic [1:0] v, input logic ie, input logic [AW-1:0] idest);
    rst           = 1'b0;
    write_back_en = wbe;
    WB_dest       = dest;
    WB_result     = res;
    src           = {s1, s0};
    src_valid     = v;
    issue_en      = ie;
    issue_dest    = idest;
    #1;
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0] = '{4'd3,  4'd14, 2'b11, 32'd3,  32'd14};
    tbl[1] = '{4'd0,  4'd1,  2'b11, 32'd0,  32'd1};
    tbl[2] = '{4'd15, 4'd7,  2'b11, 32'd0,  32'd7};
    tbl[3] = '{4'd9,  4'd15, 2'b01, 32'd9,  32'd0};
    tbl[4] = '{4'd12, 4'd12, 2'b11, 32'd12, 32'd12};
    tbl[5] = '{4'd6,  4'd2,  2'b00, 32'd6,  32'd2};

    applyStimulus(1'b1, 4'd3, 32'h5555_5555, 4'd0, 4'd0, 2'b00, 1'b1, 4'd4);
    rst = 1'b1;
    step();

    // Reset state read through every kind of address pattern
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 4'd0, 32'd0, tbl[i].s0, tbl[i].s1, tbl[i].v, 1'b0, 4'd0);
      checkValue($sformatf("reset_tbl%0d.out0", i), 64'(reg_out[W-1:0]), 64'(tbl[i].e0));
      checkValue($sformatf("reset_tbl%0d.out1", i), 64'(reg_out[2*W-1:W]), 64'(tbl[i].e1));
      checkValue($sformatf("reset_tbl%0d.hazard", i), 64'(hazard), 64'd0);
      checkValue($sformatf("reset_tbl%0d.pending", i), 64'(pending), 64'd0);
    end

    // Write then read
    applyStimulus(1'b1, 4'd5, 32'hDEAD_BEEF, 4'd5, 4'd0, 2'b01, 1'b0, 4'd0);
    checkValue("wr_same_cycle", 64'(reg_out[W-1:0]), BYPASS ? 64'hDEAD_BEEF : 64'd5);
    checkOutput("wr_same_cycle_model");
    step();
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd5, 4'd0, 2'b01, 1'b0, 4'd0);
    checkValue("wr_next_cycle", 64'(reg_out[W-1:0]), 64'hDEAD_BEEF);

    // Scoreboard lifecycle on register 7
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 2'b00, 1'b1, 4'd7);
    step();
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd0, 4'd7, 2'b10, 1'b0, 4'd0);
    checkValue("sb_hazard_set", 64'(hazard), 64'b10);
    checkValue("sb_pending_set", 64'(pending), 64'h0080);
    applyStimulus(1'b1, 4'd7, 32'h1234_5678, 4'd0, 4'd7, 2'b10, 1'b0, 4'd0);
    checkValue("sb_hazard_wb_cycle", 64'(hazard), BYPASS ? 64'b00 : 64'b10);
    checkValue("sb_data_wb_cycle", 64'(reg_out[2*W-1:W]), BYPASS ? 64'h1234_5678 : 64'd7);
    step();
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd0, 4'd7, 2'b10, 1'b0, 4'd0);
    checkValue("sb_hazard_after_wb", 64'(hazard), 64'b00);
    checkValue("sb_data_after_wb", 64'(reg_out[2*W-1:W]), 64'h1234_5678);

    // Simultaneous set and clear on register 2
    applyStimulus(1'b1, 4'd2, 32'hCAFE_0002, 4'd2, 4'd0, 2'b01, 1'b1, 4'd2);
    checkOutput("setclr_cycle");
    step();
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd2, 4'd0, 2'b01, 1'b0, 4'd0);
    checkValue("setclr_pending", 64'(pending), 64'h0004);
    checkValue("setclr_hazard", 64'(hazard), 64'b01);
    checkValue("setclr_data", 64'(reg_out[W-1:0]), 64'hCAFE_0002);

    // Out-of-range write, issue and read
    applyStimulus(1'b1, 4'd15, 32'hFFFF_FFFF, 4'd15, 4'd14, 2'b11, 1'b1, 4'd15);
    checkValue("oor_out0", 64'(reg_out[W-1:0]), 64'd0);
    checkValue("oor_hazard0", 64'(hazard[0]), 64'd0);
    step();
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd15, 4'd14, 2'b11, 1'b0, 4'd0);
    checkValue("oor_pending", 64'(pending), 64'h0004);
    checkValue("oor_r14", 64'(reg_out[2*W-1:W]), 64'd14);

    // Reset in the middle of outstanding work
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 2'b00, 1'b1, 4'd3);
    step();
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 2'b00, 1'b1, 4'd9);
    step();
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd3, 4'd9, 2'b11, 1'b0, 4'd0);
    checkValue("midrst_pending_before", 64'(pending), 64'h020C);
    applyStimulus(1'b1, 4'd3, 32'hAAAA_AAAA, 4'd3, 4'd9, 2'b11, 1'b0, 4'd0);
    rst = 1'b1;
    step();
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd3, 4'd9, 2'b11, 1'b0, 4'd0);
    checkValue("midrst_pending", 64'(pending), 64'd0);
    checkValue("midrst_r3", 64'(reg_out[W-1:0]), 64'd3);
    checkValue("midrst_hazard", 64'(hazard), 64'd0);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), W'($urandom),
                    AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));
      if ($urandom_range(0, 63) == 0) rst = 1'b1;
      checkOutput($sformatf("rand%0d", c));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
